// File: rtl/relax_osc_freq_counter.sv
// Counts synchronised rising edges of an asynchronous oscillator input over a fixed gate window.
// A new result is latched every GATE_CYCLES+2 clocks while enabled; there is no backpressure and valid pulses for one cycle.
module relax_osc_freq_counter #(
    parameter int GATE_CYCLES = 10000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       osc_in,
    input  logic       byte_sel,
    output logic [7:0] count_out,
    output logic       valid,
    output logic       ovf,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam int               TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_det;
    logic [1:0]             state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic                   ovf_run_q, ovf_run_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic [7:0]             hi_byte;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], osc_in};
    assign prev_d   = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        ovf_run_d = ovf_run_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                tmr_d     = '0;
                cnt_d     = '0;
                ovf_run_d = 1'b0;
                state_d   = S_COUNT;
            end
            S_COUNT: begin
                if (!ena) begin
                    state_d = S_IDLE;
                end else begin
                    if (edge_det) begin
                        if (cnt_q == CNT_MAX) begin
                            ovf_run_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // Final gate cycle: its edge is already folded into cnt_d, so the
                    // result is latched here and is visible together with valid.
                    if (tmr_q == TMR_LAST) begin
                        state_d  = S_LATCH;
                        result_d = cnt_d;
                        ovf_d    = ovf_run_d;
                        valid_d  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_LATCH: begin
                state_d = ena ? S_ARM : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cnt_q     <= '0;
            ovf_run_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            ovf_run_q <= ovf_run_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        hi_byte              = '0;
        hi_byte[CNT_W-9:0]   = result_q[CNT_W-1:8];
    end

    assign count_out = byte_sel ? hi_byte : result_q[7:0];
    assign valid     = valid_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/relax_osc_freq_counter.md
Name: relax_osc_freq_counter

Overview:
- Digital stage directly downstream of the analog relaxation oscillator.
- Takes the oscillator's comparator output on a digital input pin, synchronises it to clk, and counts rising edges over a fixed gate window.
- Presents the latched count byte-wise on the dedicated outputs, so the oscillator frequency is read without a scope: f_osc = count * f_clk / GATE_CYCLES.

Parameters:
GATE_CYCLES, 10000, gate window length in clk cycles (>= 2)
CNT_W, 16, edge-counter/result width (9..16); upper byte zero-extended
SYNC_STAGES, 2, synchroniser flops on osc_in (>= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  enable; high = measure continuously
osc_in  input  1  raw oscillator comparator output, asynchronous to clk
byte_sel  input  1  0 = result[7:0] on count_out, 1 = result[CNT_W-1:8]
count_out  output  8  selected byte of latched result
valid  output  1  one-cycle pulse when a new result is latched
ovf  output  1  last latched result saturated
busy  output  1  high in ARM/COUNT/LATCH

Behaviour:
- Reset: rst_n sampled low at a clk rising edge clears all of the following: synchroniser, edge history, gate timer, edge counter, result, ovf, valid. State goes to IDLE. count_out=0, valid=0, ovf=0, busy=0. Reset asserted mid-measurement discards it.
- Synchroniser: osc_in passes through SYNC_STAGES flops. edge = sync_out & ~sync_prev (registered previous sync_out). A rising osc_in reaches edge SYNC_STAGES+1 cycles later.
- Edges narrower than one clk period may be missed. This is acceptable; osc must be < f_clk/2.
- FSM states: IDLE, ARM, COUNT, LATCH.
  - IDLE: if ena=1, go to ARM next cycle.
  - ARM (1 cycle): gate timer := 0; edge counter := 0; ovf_run := 0. Any edge in this cycle is ignored. Go to COUNT.
  - COUNT: timer increments every cycle.
    - Each edge increments the edge counter, saturating at 2^CNT_W-1. An edge arriving at saturation sets ovf_run.
    - When timer == GATE_CYCLES-1, that cycle's edge is still counted and the FSM goes to LATCH.
    - Total: exactly GATE_CYCLES cycles sampled.
    - If ena=0 in any COUNT cycle, go to IDLE. result, ovf and valid are untouched.
  - LATCH (1 cycle): result := edge counter; ovf := ovf_run; valid=1 for this cycle only. Edges in this cycle are ignored. Next state is ARM if ena=1, else IDLE.
- Continuous measurement period: GATE_CYCLES+2 cycles.
- count_out: combinational mux of the registered result by byte_sel. byte_sel may change at any time, with effect in the same cycle.
- ovf and result hold until the next LATCH or reset.
- busy=1 in ARM, COUNT and LATCH.

Test Plan:
1. Reset: osc_in toggling, ena=1, rst_n=0 for 3 cycles -> count_out=0, valid=0, ovf=0, busy=0 throughout. First valid pulse arrives GATE_CYCLES+3 cycles after rst_n rises (IDLE, ARM, COUNT..., LATCH).
2. Basic: GATE_CYCLES=100, osc period 10 clk running steadily -> every result=10, byte_sel=0 gives count_out=0x0A, valid pulses exactly 102 cycles apart, ovf=0.
3. Byte select: GATE_CYCLES=1000, osc period 2 clk -> result=500=0x01F4; byte_sel=0 gives 0xF4, byte_sel=1 gives 0x01.
4. Overflow: CNT_W=9, GATE_CYCLES=1200, osc period 2 -> result=511 (count_out=0xFF/0x01), ovf=1. Next gate with osc_in held high -> result=0, ovf=0.
5. Abort: previous result=10; drop ena at timer=50 -> no valid pulse, count_out stays 0x0A, busy=0 next cycle. Re-raise ena -> ARM next cycle, then a new result=10 after 102 cycles.
6. Gate boundary: single isolated osc pulse whose edge is detected in the last COUNT cycle -> counted (result=1). Same pulse shifted to be detected in the LATCH or ARM cycle -> not counted (result=0).
